// File: rtl/rob_sn_alloc_pkg.sv
// Shared defaults and helpers for the ROB sequence-number allocator.
// ROB_DEPTH / ROB_BITWIDTH normally arrive from common_defs.v; fall back to sane defaults.
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef ROB_BITWIDTH
`define ROB_BITWIDTH 8
`endif

package rob_sn_alloc_pkg;

  // Sequence-number width for a given depth; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rob_WrapPtr.sv
// Pointer register that advances by one and wraps from p_depth-1 back to 0.
module rob_WrapPtr #(
  parameter int unsigned p_depth    = 8,
  parameter int unsigned p_ptrwidth = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  incr,
  output logic [p_ptrwidth-1:0] ptr
);

  localparam logic [p_ptrwidth-1:0] Last = p_ptrwidth'(p_depth - 1);

  logic [p_ptrwidth-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (incr) begin
      ptr_d = (ptr_q == Last) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rob_sn_alloc.sv
// Stamps in-order requests with ROB sequence numbers and issues them through a one-entry slot.
// Optional sticky retire-underflow flag: define ROB_SN_ALLOC_ERR_EN.
module rob_sn_alloc
  import rob_sn_alloc_pkg::*;
#(
  parameter int unsigned p_depth    = `ROB_DEPTH,
  parameter int unsigned p_ptrwidth = ptr_width(p_depth),
  parameter int unsigned p_bitwidth = `ROB_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  output logic                  req_cpl,
  input  logic [p_bitwidth-1:0] req_data,
  output logic                  iss_val,
  input  logic                  iss_rdy,
  output logic [p_ptrwidth-1:0] iss_sn,
  output logic [p_bitwidth-1:0] iss_data,
  input  logic                  deq_front_cpl,
  output logic [p_ptrwidth-1:0] head_sn,
  output logic [p_ptrwidth:0]   count,
  output logic                  full,
`ifdef ROB_SN_ALLOC_ERR_EN
  output logic                  empty,
  output logic                  err
`else
  output logic                  empty
`endif
);

  localparam logic [p_ptrwidth:0] CountMax = (p_ptrwidth + 1)'(p_depth);

  logic [p_ptrwidth-1:0] tail;
  logic [p_ptrwidth:0]   count_q, count_d;
  logic                  iss_val_q;
  logic [p_ptrwidth-1:0] iss_sn_q;
  logic [p_bitwidth-1:0] iss_data_q;
  logic                  accept, retire;

  assign full    = (count_q == CountMax);
  assign empty   = (count_q == '0);
  // Capacity is taken at accept, so a full allocator stays blocked even on a same-cycle retire.
  assign accept  = req_en && !full && (!iss_val_q || iss_rdy);
  assign retire  = deq_front_cpl && !empty;
  assign req_cpl = accept;

  rob_WrapPtr #(
    .p_depth   (p_depth),
    .p_ptrwidth(p_ptrwidth)
  ) u_tail (
    .clk (clk),
    .rst (rst),
    .incr(accept),
    .ptr (tail)
  );

  rob_WrapPtr #(
    .p_depth   (p_depth),
    .p_ptrwidth(p_ptrwidth)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .incr(retire),
    .ptr (head_sn)
  );

  always_comb begin
    count_d = count_q;
    unique case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      iss_val_q  <= 1'b0;
      iss_sn_q   <= '0;
      iss_data_q <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        iss_val_q  <= 1'b1;
        iss_sn_q   <= tail;
        iss_data_q <= req_data;
      end else if (iss_val_q && iss_rdy) begin
        iss_val_q <= 1'b0;
      end
    end
  end

`ifdef ROB_SN_ALLOC_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (deq_front_cpl && empty) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign count    = count_q;
  assign iss_val  = iss_val_q;
  assign iss_sn   = iss_sn_q;
  assign iss_data = iss_data_q;

endmodule

// File: tb/tb_rob_sn_alloc.sv
// Directed bench for rob_sn_alloc: depth-8 instance for most scenarios, depth-6 for odd wrap.
module tb_rob_sn_alloc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Depth-8 instance
  logic       a_req_en, a_req_cpl, a_iss_val, a_iss_rdy, a_deq, a_full, a_empty;
  logic [7:0] a_req_data, a_iss_data;
  logic [2:0] a_iss_sn, a_head_sn;
  logic [3:0] a_count;
`ifdef ROB_SN_ALLOC_ERR_EN
  logic       a_err;
`endif

  // Depth-6 instance
  logic       b_req_en, b_req_cpl, b_iss_val, b_iss_rdy, b_deq, b_full, b_empty;
  logic [7:0] b_req_data, b_iss_data;
  logic [2:0] b_iss_sn, b_head_sn;
  logic [3:0] b_count;
`ifdef ROB_SN_ALLOC_ERR_EN
  logic       b_err;
`endif

  rob_sn_alloc #(
    .p_depth   (8),
    .p_ptrwidth(3),
    .p_bitwidth(8)
  ) dut8 (
    .clk          (clk),
    .rst          (rst),
    .req_en       (a_req_en),
    .req_cpl      (a_req_cpl),
    .req_data     (a_req_data),
    .iss_val      (a_iss_val),
    .iss_rdy      (a_iss_rdy),
    .iss_sn       (a_iss_sn),
    .iss_data     (a_iss_data),
    .deq_front_cpl(a_deq),
    .head_sn      (a_head_sn),
    .count        (a_count),
    .full         (a_full),
`ifdef ROB_SN_ALLOC_ERR_EN
    .empty        (a_empty),
    .err          (a_err)
`else
    .empty        (a_empty)
`endif
  );

  rob_sn_alloc #(
    .p_depth   (6),
    .p_ptrwidth(3),
    .p_bitwidth(8)
  ) dut6 (
    .clk          (clk),
    .rst          (rst),
    .req_en       (b_req_en),
    .req_cpl      (b_req_cpl),
    .req_data     (b_req_data),
    .iss_val      (b_iss_val),
    .iss_rdy      (b_iss_rdy),
    .iss_sn       (b_iss_sn),
    .iss_data     (b_iss_data),
    .deq_front_cpl(b_deq),
    .head_sn      (b_head_sn),
    .count        (b_count),
    .full         (b_full),
`ifdef ROB_SN_ALLOC_ERR_EN
    .empty        (b_empty),
    .err          (b_err)
`else
    .empty        (b_empty)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req_en = 0; a_req_data = '0; a_iss_rdy = 1; a_deq = 0;
    b_req_en = 0; b_req_data = '0; b_iss_rdy = 1; b_deq = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (a_iss_val !== 1'b0) begin
      miscompares++; $display("FAIL reset_iss_val got %b want 0", a_iss_val);
    end
    vectors++;
    if (a_iss_sn !== 3'd0 || a_iss_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_iss_sn_data got %0d/%h want 0/00", a_iss_sn, a_iss_data);
    end
    vectors++;
    if (a_head_sn !== 3'd0 || a_count !== 4'd0) begin
      miscompares++; $display("FAIL reset_head_count got %0d/%0d want 0/0", a_head_sn, a_count);
    end
    vectors++;
    if (a_full !== 1'b0 || a_empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_full_empty got %b/%b want 0/1", a_full, a_empty);
    end
`ifdef ROB_SN_ALLOC_ERR_EN
    vectors++;
    if (a_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err got %b want 0", a_err);
    end
`endif
  endtask

  task automatic test_first_accept();
    do_reset();
    a_req_en = 1; a_req_data = 8'hA5; a_iss_rdy = 1;
    #1;
    vectors++;
    if (a_req_cpl !== 1'b1) begin
      miscompares++; $display("FAIL first_req_cpl got %b want 1", a_req_cpl);
    end
    tick();
    a_req_en = 0;
    vectors++;
    if (a_iss_val !== 1'b1 || a_iss_sn !== 3'd0 || a_iss_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL first_issue got val=%b sn=%0d data=%h want 1/0/a5",
               a_iss_val, a_iss_sn, a_iss_data);
    end
    vectors++;
    if (a_count !== 4'd1 || a_empty !== 1'b0) begin
      miscompares++; $display("FAIL first_count got %0d/%b want 1/0", a_count, a_empty);
    end
    tick();
    vectors++;
    if (a_iss_val !== 1'b0 || a_count !== 4'd1) begin
      miscompares++; $display("FAIL first_drain got val=%b cnt=%0d want 0/1", a_iss_val, a_count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    a_iss_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      a_req_en = 1; a_req_data = 8'(8'h10 + i);
      #1;
      vectors++;
      if (a_req_cpl !== (i < 8)) begin
        miscompares++; $display("FAIL fill_req_cpl[%0d] got %b want %b", i, a_req_cpl, i < 8);
      end
      tick();
      if (i < 8) begin
        vectors++;
        if (a_iss_sn !== 3'(i) || a_iss_data !== 8'(8'h10 + i)) begin
          miscompares++;
          $display("FAIL fill_sn[%0d] got %0d/%h want %0d/%h", i, a_iss_sn, a_iss_data, i,
                   8'(8'h10 + i));
        end
      end
      if (i == 7) begin
        vectors++;
        if (a_full !== 1'b1 || a_count !== 4'd8) begin
          miscompares++; $display("FAIL fill_full got %b/%0d want 1/8", a_full, a_count);
        end
      end
    end
    a_req_en = 0;
  endtask

  // Runs straight after test_fill: allocator full, issue slot drained.
  task automatic test_full_retire();
    a_req_en = 1; a_req_data = 8'h77; a_deq = 1;
    #1;
    vectors++;
    if (a_req_cpl !== 1'b0) begin
      miscompares++; $display("FAIL full_retire_req_cpl got %b want 0", a_req_cpl);
    end
    tick();
    a_deq = 0;
    vectors++;
    if (a_count !== 4'd7 || a_head_sn !== 3'd1 || a_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_retire_state got cnt=%0d head=%0d full=%b want 7/1/0",
               a_count, a_head_sn, a_full);
    end
    #1;
    vectors++;
    if (a_req_cpl !== 1'b1) begin
      miscompares++; $display("FAIL wrap_req_cpl got %b want 1", a_req_cpl);
    end
    tick();
    a_req_en = 0;
    vectors++;
    if (a_iss_sn !== 3'd0 || a_iss_data !== 8'h77 || a_count !== 4'd8) begin
      miscompares++;
      $display("FAIL wrap_issue got sn=%0d data=%h cnt=%0d want 0/77/8",
               a_iss_sn, a_iss_data, a_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    a_iss_rdy = 0; a_req_en = 1; a_req_data = 8'h11;
    tick();
    a_req_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (a_req_cpl !== 1'b0) begin
        miscompares++; $display("FAIL stall_req_cpl[%0d] got %b want 0", i, a_req_cpl);
      end
      tick();
      vectors++;
      if (a_iss_val !== 1'b1 || a_iss_sn !== 3'd0 || a_iss_data !== 8'h11) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got %b/%0d/%h want 1/0/11",
                 i, a_iss_val, a_iss_sn, a_iss_data);
      end
    end
    a_iss_rdy = 1;
    #1;
    vectors++;
    if (a_req_cpl !== 1'b1) begin
      miscompares++; $display("FAIL stall_release_req_cpl got %b want 1", a_req_cpl);
    end
    tick();
    vectors++;
    if (a_iss_val !== 1'b1 || a_iss_sn !== 3'd1 || a_iss_data !== 8'h22 || a_count !== 4'd2) begin
      miscompares++;
      $display("FAIL stall_refill got %b/%0d/%h cnt=%0d want 1/1/22/2",
               a_iss_val, a_iss_sn, a_iss_data, a_count);
    end
    // Reset while busy discards everything, despite a pending request.
    rst = 1;
    tick();
    rst = 0;
    a_req_en = 0;
    vectors++;
    if (a_iss_val !== 1'b0 || a_count !== 4'd0 || a_iss_sn !== 3'd0) begin
      miscompares++;
      $display("FAIL midreset got val=%b cnt=%0d sn=%0d want 0/0/0", a_iss_val, a_count, a_iss_sn);
    end
  endtask

  task automatic test_wrap6();
    do_reset();
    b_iss_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      b_req_en = 1; b_req_data = 8'(8'h60 + i);
      tick();
    end
    b_req_en = 0;
    vectors++;
    if (b_full !== 1'b1 || b_count !== 4'd6 || b_iss_sn !== 3'd5) begin
      miscompares++;
      $display("FAIL d6_full got full=%b cnt=%0d sn=%0d want 1/6/5", b_full, b_count, b_iss_sn);
    end
    b_deq = 1;
    for (int i = 0; i < 6; i++) tick();
    b_deq = 0;
    vectors++;
    if (b_empty !== 1'b1 || b_head_sn !== 3'd0) begin
      miscompares++; $display("FAIL d6_drain got empty=%b head=%0d want 1/0", b_empty, b_head_sn);
    end
    b_req_en = 1; b_req_data = 8'h66;
    tick();
    b_req_en = 0;
    vectors++;
    if (b_iss_sn !== 3'd0 || b_iss_data !== 8'h66 || b_head_sn !== 3'd0 || b_count !== 4'd1) begin
      miscompares++;
      $display("FAIL d6_wrap got sn=%0d data=%h head=%0d cnt=%0d want 0/66/0/1",
               b_iss_sn, b_iss_data, b_head_sn, b_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    a_deq = 1;
    tick();
    a_deq = 0;
    vectors++;
    if (a_count !== 4'd0 || a_head_sn !== 3'd0 || a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_state got cnt=%0d head=%0d empty=%b want 0/0/1",
               a_count, a_head_sn, a_empty);
    end
`ifdef ROB_SN_ALLOC_ERR_EN
    vectors++;
    if (a_err !== 1'b1) begin
      miscompares++; $display("FAIL underflow_err got %b want 1", a_err);
    end
    tick();
    tick();
    vectors++;
    if (a_err !== 1'b1) begin
      miscompares++; $display("FAIL underflow_err_sticky got %b want 1", a_err);
    end
    do_reset();
    vectors++;
    if (a_err !== 1'b0) begin
      miscompares++; $display("FAIL underflow_err_clear got %b want 0", a_err);
    end
`endif
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_first_accept();
    test_fill();
    test_full_retire();
    test_stall();
    test_wrap6();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
